// File: rtl/xbar_rx_port_if.sv
// Crossbar receive-port bus: incoming crossbar word plus the consumer-side
// valid/ready handshake. The port itself uses the slave view.
interface xbar_rx_port_if;
  logic [9:0] sd;
  logic       sd_valid;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_src;

  modport master (
    output sd, sd_valid, out_ready,
    input  out_valid, out_data, out_src
  );

  modport slave (
    input  sd, sd_valid, out_ready,
    output out_valid, out_data, out_src
  );
endinterface

// File: rtl/xbar_rx_port.sv
// Crossbar receive port: buffers tagged crossbar words in a small FIFO,
// flags words dropped while full (sticky), and keeps a saturating count of
// accepted words per source id.
module xbar_rx_port #(
  parameter int DEPTH = 4,
  parameter int CW    = 8,
  localparam int LW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  xbar_rx_port_if.slave     rx,
  input  logic              cnt_clr,
  input  logic              ovf_clr,
  output logic [LW-1:0]     level,
  output logic              ovf,
  output logic [CW-1:0]     cnt0,
  output logic [CW-1:0]     cnt1,
  output logic [CW-1:0]     cnt2,
  output logic [CW-1:0]     cnt3
);

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [9:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  logic          not_empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [9:0]    head;

  assign not_empty = (level_q != '0);
  assign full      = (level_q == LVL_FULL);
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign pop       = not_empty & rx.out_ready;
  assign push      = rx.sd_valid & (~full | pop);
  assign drop      = rx.sd_valid & full & ~pop;

  // Pointer, occupancy and sticky-overflow next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A new drop wins over a coincident clear.
    ovf_d = drop | (ovf_q & ~ovf_clr);
  end

  // Per-source saturating counters; clear beats a coincident increment.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr) begin
        cnt_d[i] = '0;
      end else if (push && (rx.sd[9:8] == 2'(i)) && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Storage array; contents are only meaningful below level, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx.sd;
  end

  // Head is read from stored state only, so a fresh word shows up a cycle later.
  assign head         = mem_q[rd_ptr_q];
  assign rx.out_valid = not_empty;
  assign rx.out_data  = not_empty ? head[7:0] : 8'h00;
  assign rx.out_src   = not_empty ? head[9:8] : 2'b00;

  assign level = level_q;
  assign ovf   = ovf_q;
  assign cnt0  = cnt_q[0];
  assign cnt1  = cnt_q[1];
  assign cnt2  = cnt_q[2];
  assign cnt3  = cnt_q[3];

endmodule

// File: tb/tb_xbar_rx_port.sv
// Bench for xbar_rx_port: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_xbar_rx_port;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cnt_clr;
  logic          ovf_clr;
  logic [LW-1:0] level;
  logic          ovf;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;

  xbar_rx_port_if bus ();

  xbar_rx_port #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (bus),
    .cnt_clr (cnt_clr),
    .ovf_clr (ovf_clr),
    .level   (level),
    .ovf     (ovf),
    .cnt0    (cnt0),
    .cnt1    (cnt1),
    .cnt2    (cnt2),
    .cnt3    (cnt3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an ordered queue of accepted words, plain counters, a flag.
  logic [9:0] mq[$];
  int         mcnt[4];
  bit         movf;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    movf = 1'b0;
  endtask

  task automatic model_step(input logic [9:0] s, input logic v, input logic r,
                            input logic cc, input logic oc);
    bit pop_m, push_m, drop_m;
    pop_m  = (mq.size() > 0) && r;
    push_m = v && ((mq.size() < DEPTH) || pop_m);
    drop_m = v && (mq.size() == DEPTH) && !pop_m;
    if (pop_m)  void'(mq.pop_front());
    if (push_m) mq.push_back(s);
    if (cc) begin
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
    end else if (push_m && mcnt[s[9:8]] < CMAX) begin
      mcnt[s[9:8]] = mcnt[s[9:8]] + 1;
    end
    if (drop_m)  movf = 1'b1;
    else if (oc) movf = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int ed, es;
    ed = 0;
    es = 0;
    if (mq.size() > 0) begin
      ed = int'(mq[0][7:0]);
      es = int'(mq[0][9:8]);
    end
    chk({tag, " out_valid"}, bus.out_valid, (mq.size() > 0) ? 1 : 0);
    chk({tag, " out_data"},  bus.out_data, ed);
    chk({tag, " out_src"},   bus.out_src, es);
    chk({tag, " level"},     level, mq.size());
    chk({tag, " ovf"},       ovf, movf);
    chk({tag, " cnt0"},      cnt0, mcnt[0]);
    chk({tag, " cnt1"},      cnt1, mcnt[1]);
    chk({tag, " cnt2"},      cnt2, mcnt[2]);
    chk({tag, " cnt3"},      cnt3, mcnt[3]);
  endtask

  // Called just after a falling edge: drive, advance the model, clock, check.
  task automatic step(input logic [9:0] s, input logic v, input logic r,
                      input logic cc, input logic oc, input string tag);
    bus.sd        = s;
    bus.sd_valid  = v;
    bus.out_ready = r;
    cnt_clr       = cc;
    ovf_clr       = oc;
    model_step(s, v, r, cc, oc);
    @(posedge clk);
    @(negedge clk);
    bus.sd_valid  = 1'b0;
    bus.out_ready = 1'b0;
    cnt_clr       = 1'b0;
    ovf_clr       = 1'b0;
    check_model(tag);
  endtask

  typedef struct {
    logic [9:0] sd;
    logic       v;
    logic       r;
    logic       oc;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] es;
    int         el;
    logic       eo;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int c0, c3;

    // Single word, then fill / overflow / drain, then clear the flag.
    tbl[0]  = '{10'h2A5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd2, 1, 1'b0};
    tbl[1]  = '{10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd2, 1, 1'b0};
    tbl[2]  = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 0, 1'b0};
    tbl[3]  = '{10'h001, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 2'd0, 1, 1'b0};
    tbl[4]  = '{10'h102, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 2'd0, 2, 1'b0};
    tbl[5]  = '{10'h203, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 2'd0, 3, 1'b0};
    tbl[6]  = '{10'h304, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 2'd0, 4, 1'b0};
    tbl[7]  = '{10'h005, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 2'd0, 4, 1'b1};
    tbl[8]  = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 2'd1, 3, 1'b1};
    tbl[9]  = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 2'd2, 2, 1'b1};
    tbl[10] = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 2'd3, 1, 1'b1};
    tbl[11] = '{10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 0, 1'b1};
    tbl[12] = '{10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 0, 1'b0};

    rst_n         = 1'b0;
    bus.sd        = '0;
    bus.sd_valid  = 1'b0;
    bus.out_ready = 1'b0;
    cnt_clr       = 1'b0;
    ovf_clr       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model("reset");
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].sd, tbl[i].v, tbl[i].r, 1'b0, tbl[i].oc, "vec");
      chk("vec out_valid", bus.out_valid, tbl[i].ev);
      chk("vec out_data",  bus.out_data,  tbl[i].ed);
      chk("vec out_src",   bus.out_src,   tbl[i].es);
      chk("vec level",     level,         tbl[i].el);
      chk("vec ovf",       ovf,           tbl[i].eo);
      $display("vec %0d: sd=%03h v=%0b r=%0b -> valid=%0b src=%0d data=%02h level=%0d ovf=%0b",
               i, tbl[i].sd, tbl[i].v, tbl[i].r, bus.out_valid, bus.out_src,
               bus.out_data, level, ovf);
    end
    chk("fill cnt2", cnt2, 2);
    chk("fill cnt1", cnt1, 1);
    chk("fill cnt3", cnt3, 1);

    // Full FIFO with simultaneous push and pop.
    step(10'h001, 1'b1, 1'b0, 1'b0, 1'b0, "pp fill");
    step(10'h102, 1'b1, 1'b0, 1'b0, 1'b0, "pp fill");
    step(10'h203, 1'b1, 1'b0, 1'b0, 1'b0, "pp fill");
    step(10'h304, 1'b1, 1'b0, 1'b0, 1'b0, "pp fill");
    c0 = int'(cnt0);
    step(10'h0FF, 1'b1, 1'b1, 1'b0, 1'b0, "pp");
    chk("pp level", level, 4);
    chk("pp ovf", ovf, 0);
    chk("pp cnt0", cnt0, c0 + 1);
    $display("full push+pop: level=%0d ovf=%0b cnt0=%0d", level, ovf, cnt0);
    for (int i = 0; i < 3; i++) step(10'h000, 1'b0, 1'b1, 1'b0, 1'b0, "pp drain");
    chk("pp last data", bus.out_data, 8'hFF);
    chk("pp last src", bus.out_src, 0);
    step(10'h000, 1'b0, 1'b1, 1'b0, 1'b0, "pp drain");
    chk("pp empty", bus.out_valid, 0);

    // Counter saturation, then clear coincident with a push.
    for (int i = 0; i < 300; i++)
      step({2'd3, 8'($urandom)}, 1'b1, 1'b1, 1'b0, 1'b0, "sat");
    chk("sat cnt3", cnt3, 255);
    $display("saturation: cnt3=%0d", cnt3);
    step(10'h3AA, 1'b1, 1'b1, 1'b1, 1'b0, "clr");
    chk("clr cnt3", cnt3, 0);
    $display("clear with push: cnt3=%0d", cnt3);

    // Reset mid-stream with level 3 and ovf set.
    for (int i = 0; i < 2; i++) step(10'h000, 1'b0, 1'b1, 1'b0, 1'b0, "rs drain");
    for (int i = 0; i < 5; i++)
      step(10'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, "rs fill");
    step(10'h000, 1'b0, 1'b1, 1'b0, 1'b0, "rs pop");
    chk("rs pre level", level, 3);
    chk("rs pre ovf", ovf, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs async out_valid", bus.out_valid, 0);
    chk("rs async out_data", bus.out_data, 0);
    chk("rs async level", level, 0);
    chk("rs async ovf", ovf, 0);
    chk("rs async cnt", int'(cnt0 | cnt1 | cnt2 | cnt3), 0);
    $display("async reset: valid=%0b level=%0d ovf=%0b", bus.out_valid, level, ovf);
    model_reset();
    bus.sd       = 10'h3FF;
    bus.sd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.sd_valid = 1'b0;
    check_model("rs held");
    rst_n = 1'b1;
    step(10'h111, 1'b1, 1'b0, 1'b0, 1'b0, "rs resume");
    chk("rs resume src", bus.out_src, 1);
    chk("rs resume data", bus.out_data, 8'h11);
    $display("after reset: src=%0d data=%02h", bus.out_src, bus.out_data);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step(10'($urandom),
           ($urandom_range(99) < 70) ? 1'b1 : 1'b0,
           ($urandom_range(99) < 50) ? 1'b1 : 1'b0,
           ($urandom_range(99) < 2)  ? 1'b1 : 1'b0,
           ($urandom_range(99) < 5)  ? 1'b1 : 1'b0,
           "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
